row_mac_engine: RTL and testbench
=================================

# row_mac_engine

Row multiply engine for the 10×10 matrix-multiply datapath; sits directly downstream of the main controller. When begin_mult is seen while idle, it computes one full result row C[r][*] = Σk A[r][k]·B[k][*] for the row r given on res_add. It reads operands from the operand buffer, writes each of the N result elements to the result buffer, and pulses done_row so the controller advances to the next row.

## Interface
Parameters:
- N, 10 — matrix dimension (rows, columns, inner length)
- IDX_W, 4 — index width; must satisfy 2^IDX_W ≥ N
- DATA_W, 8 — unsigned operand width
- ACC_W, 2*DATA_W+4 — accumulator and result width

Ports:
- clk  in  1  clock
- n_reset  in  1  asynchronous, active-low reset
- begin_mult  in  1  start request from controller; level, sampled only in IDLE
- res_add  in  IDX_W  result row index r; latched at start
- op_rd_en  out  1  operand read strobe
- op_row  out  IDX_W  A row index (= latched r)
- op_k  out  IDX_W  inner index k (A column / B row)
- op_col  out  IDX_W  B column index c
- a_rdata  in  DATA_W  A[r][k]; valid the cycle after op_rd_en
- b_rdata  in  DATA_W  B[k][c]; valid the cycle after op_rd_en
- res_wr_en  out  1  result write strobe, one cycle per element
- res_row  out  IDX_W  result row r
- res_col  out  IDX_W  result column c
- res_data  out  ACC_W  C[r][c]
- done_row  out  1  single-cycle pulse: row complete

## Operation
States:
- **IDLE**
  - If begin_mult=1: latch row ← res_add, set col ← 0, k ← 0, clear acc, go to RUN.
  - Otherwise stay in IDLE.
- **RUN**
  - op_rd_en=1 with op_k=k and op_col=col.
  - k increments each cycle; when k=N-1, go to DRAIN.
- **DRAIN**
  - op_rd_en=0.
  - Accumulates the last product; go to WRITE.
- **WRITE**
  - res_wr_en=1, res_data=acc, res_row=row, res_col=col.
  - If col=N-1, go to DONE.
  - Otherwise col++, k←0, clear acc, go to RUN.
- **DONE**
  - done_row=1; go to IDLE.

Datapath and control rules:
- Accumulate: valid_d is op_rd_en delayed one cycle. On each edge with valid_d=1, acc ← acc + a_rdata·b_rdata.
- Arithmetic is unsigned and wraps modulo 2^ACC_W. At default parameters the maximum is 10·255·255 = 650250, which fits in 20 bits, so no wrap occurs.
- begin_mult is ignored outside IDLE. Deasserting it mid-row does not abort; the row completes.
- Controller handshake: the controller advances on the same edge that samples done_row and raises begin_mult with the next res_add. The engine returns to IDLE after DONE and starts the next row on the following edge. It never restarts from DONE.
- When not in the states listed above:
  - op_row, op_k and op_col hold their last values.
  - res_row and res_col hold their last values.
  - res_data holds acc.

## Timing
- Reset values: state=IDLE and op_rd_en=0. res_wr_en, done_row, op_row, op_k, op_col, res_row, res_col, res_data, acc and valid_d are all 0.
- Reset mid-row: immediate return to IDLE. Partial results are discarded and no done_row is issued.
- Start edge is cycle 0. Column c occupies cycles (N+2)c+1 … (N+2)c+N+2:
  - N RUN cycles
  - 1 DRAIN cycle
  - 1 WRITE cycle (the last cycle of the column)
- For N=10:
  - Writes occur in cycles 12, 24, …, 120.
  - done_row is high in cycle 121 (N(N+2)+1).
  - The engine is in IDLE in cycle 122 and can start the next row on the edge ending cycle 122.
- Operand buffer read latency is exactly 1 cycle and is not stallable.
- The result buffer accepts a write every cycle that res_wr_en is high.

## Structure
- Package matmul_pkg holds:
  - N, IDX_W, DATA_W, ACC_W constants
  - row_state_t enum {IDLE, RUN, DRAIN, WRITE, DONE}
- The main controller takes its row count from the same package constant.
- Sub-module mac_unit (DATA_W, ACC_W): clear, en, a, b → acc register. It is used once and owns the multiply and the wrap rule.

## Test plan
- Reset, then idle with begin_mult=0 for 20 cycles → all outputs 0 and no op_rd_en.
- A=identity, B[k][c]=10k+c, begin_mult with res_add=3 → 10 writes with res_row=3 and res_col 0..9, res_data=30..39 in cycles 12..120, done_row pulse in cycle 121.
- All operands 255, res_add=9 → every res_data=650250, no wrap.
- Controller handshake: begin_mult held high while res_add steps 0→1 on the done_row edge → row 1 starts on the edge ending cycle 122, and the second done_row arrives 122 cycles after the first.
- begin_mult dropped at cycle 5 of a row → row still completes with 10 writes and one done_row.
- n_reset asserted at cycle 50 with begin_mult=0 at release → no further writes, no done_row, state IDLE; a fresh start afterwards yields correct results.

Source files
------------

// File: rtl/row_mac_engine_pkg.sv
// Shared constants and state encoding for the 10x10 matrix-multiply datapath.
package matmul_pkg;
    localparam int N      = 10;
    localparam int IDX_W  = 4;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 2*DATA_W + 4;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        WRITE,
        DONE
    } row_state_t;
endpackage

// File: rtl/row_mac_engine_if.sv
// Controller, operand-buffer and result-buffer signals seen by the row engine.
interface row_mac_engine_if;
    import matmul_pkg::*;

    logic              begin_mult;
    logic [IDX_W-1:0]  res_add;
    logic              op_rd_en;
    logic [IDX_W-1:0]  op_row;
    logic [IDX_W-1:0]  op_k;
    logic [IDX_W-1:0]  op_col;
    logic [DATA_W-1:0] a_rdata;
    logic [DATA_W-1:0] b_rdata;
    logic              res_wr_en;
    logic [IDX_W-1:0]  res_row;
    logic [IDX_W-1:0]  res_col;
    logic [ACC_W-1:0]  res_data;
    logic              done_row;

    modport master (
        output begin_mult, res_add, a_rdata, b_rdata,
        input  op_rd_en, op_row, op_k, op_col,
        input  res_wr_en, res_row, res_col, res_data, done_row
    );

    modport slave (
        input  begin_mult, res_add, a_rdata, b_rdata,
        output op_rd_en, op_row, op_k, op_col,
        output res_wr_en, res_row, res_col, res_data, done_row
    );
endinterface

// File: rtl/row_mac_engine_mac_unit.sv
// Unsigned multiply-accumulate register; sums wrap modulo 2^ACC_W.
module mac_unit #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              clear,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc
);
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;

    function automatic logic [ACC_W-1:0] mac_wrap(input logic [ACC_W-1:0]  acc_in,
                                                  input logic [DATA_W-1:0] x,
                                                  input logic [DATA_W-1:0] y);
        logic [2*DATA_W-1:0] prod;
        prod = {{DATA_W{1'b0}}, x} * {{DATA_W{1'b0}}, y};
        return acc_in + ACC_W'(prod);
    endfunction

    // clear wins over en so a new column never inherits a stale product
    always_comb begin
        acc_d = acc_q;
        if (clear)
            acc_d = '0;
        else if (en)
            acc_d = mac_wrap(acc_q, a, b);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

    assign acc = acc_q;
endmodule

// File: rtl/row_mac_engine.sv
// Computes one result row C[r][*] = sum_k A[r][k]*B[k][*], one column per N+2 cycles.
module row_mac_engine
    import matmul_pkg::*;
(
    input  logic             clk,
    input  logic             n_reset,
    row_mac_engine_if.slave  bus
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N-1);

    row_state_t       state_q, state_d;
    logic [IDX_W-1:0] row_q, row_d;
    logic [IDX_W-1:0] col_q, col_d;
    logic [IDX_W-1:0] k_q, k_d;
    logic             valid_q;
    logic             mac_clr;
    logic [ACC_W-1:0] acc;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            k_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            k_q     <= k_d;
            valid_q <= bus.op_rd_en;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        k_d     = k_q;
        mac_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.begin_mult) begin
                    row_d   = bus.res_add;
                    col_d   = '0;
                    k_d     = '0;
                    mac_clr = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (k_q == LAST_IDX)
                    state_d = DRAIN;
                else
                    k_d = k_q + 1'b1;
            end
            // last read's data arrives now and is summed on this edge
            DRAIN: state_d = WRITE;
            WRITE: begin
                if (col_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    col_d   = col_q + 1'b1;
                    k_d     = '0;
                    mac_clr = 1'b1;
                    state_d = RUN;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk     (clk),
        .n_reset (n_reset),
        .clear   (mac_clr),
        .en      (valid_q),
        .a       (bus.a_rdata),
        .b       (bus.b_rdata),
        .acc     (acc)
    );

    assign bus.op_rd_en  = (state_q == RUN);
    assign bus.op_row    = row_q;
    assign bus.op_k      = k_q;
    assign bus.op_col    = col_q;
    assign bus.res_wr_en = (state_q == WRITE);
    assign bus.res_row   = row_q;
    assign bus.res_col   = col_q;
    assign bus.res_data  = acc;
    assign bus.done_row  = (state_q == DONE);
endmodule

// File: tb/tb_row_mac_engine.sv
// Directed bench for row_mac_engine with a one-cycle-latency operand buffer model.
module tb_row_mac_engine;
    import matmul_pkg::*;

    logic clk = 1'b0;
    logic n_reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [7:0] a_mem [10][10];
    logic [7:0] b_mem [10][10];

    row_mac_engine_if bus ();

    row_mac_engine dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.op_rd_en) begin
            bus.a_rdata <= a_mem[bus.op_row][bus.op_k];
            bus.b_rdata <= b_mem[bus.op_k][bus.op_col];
        end
    end

    task automatic load_identity();
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < 10; j++) begin
                a_mem[i][j] = (i == j) ? 8'd1 : 8'd0;
                b_mem[i][j] = 8'(10*i + j);
            end
    endtask

    task automatic load_full();
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < 10; j++) begin
                a_mem[i][j] = 8'd255;
                b_mem[i][j] = 8'd255;
            end
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        bus.begin_mult = 1'b0;
        bus.res_add = '0;
        repeat (3) @(posedge clk);
        #1 n_reset = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({bus.op_rd_en, bus.res_wr_en, bus.done_row, bus.op_row, bus.op_k, bus.op_col,
                 bus.res_row, bus.res_col, bus.res_data} !== '0) begin
                n_bad++;
                $display("FAIL reset_idle cyc=%0d got rd=%b wr=%b done=%b data=%0d required all zero",
                         cyc, bus.op_rd_en, bus.res_wr_en, bus.done_row, bus.res_data);
            end
        end
    endtask

    task automatic test_identity();
        bit exp_wr, exp_rd, exp_done;
        load_identity();
        bus.res_add = 4'd3;
        bus.begin_mult = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 122; cyc++) begin
            #1;
            if (cyc == 1) bus.begin_mult = 1'b0;
            exp_wr   = (cyc % 12 == 0) && (cyc <= 120);
            exp_rd   = (cyc % 12 >= 1) && (cyc % 12 <= 10) && (cyc <= 120);
            exp_done = (cyc == 121);
            n_cmp++;
            if (bus.res_wr_en !== exp_wr) begin
                n_bad++;
                $display("FAIL id_wr_en cyc=%0d got=%b required=%b", cyc, bus.res_wr_en, exp_wr);
            end
            n_cmp++;
            if (bus.op_rd_en !== exp_rd) begin
                n_bad++;
                $display("FAIL id_rd_en cyc=%0d got=%b required=%b", cyc, bus.op_rd_en, exp_rd);
            end
            n_cmp++;
            if (bus.done_row !== exp_done) begin
                n_bad++;
                $display("FAIL id_done cyc=%0d got=%b required=%b", cyc, bus.done_row, exp_done);
            end
            if (exp_wr) begin
                n_cmp++;
                if (bus.res_row !== 4'd3 || bus.res_col !== 4'(cyc/12 - 1) ||
                    bus.res_data !== 20'(30 + cyc/12 - 1)) begin
                    n_bad++;
                    $display("FAIL id_write cyc=%0d got row=%0d col=%0d data=%0d required row=3 col=%0d data=%0d",
                             cyc, bus.res_row, bus.res_col, bus.res_data, cyc/12 - 1, 30 + cyc/12 - 1);
                end
            end
            @(posedge clk);
        end
        #1;
    endtask

    task automatic test_full_scale();
        int wcount = 0;
        int done_cyc = 0;
        load_full();
        bus.res_add = 4'd9;
        bus.begin_mult = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 125; cyc++) begin
            #1;
            if (cyc == 1) bus.begin_mult = 1'b0;
            if (bus.res_wr_en) begin
                n_cmp++;
                if (bus.res_data !== 20'd650250 || bus.res_row !== 4'd9 || bus.res_col !== 4'(wcount)) begin
                    n_bad++;
                    $display("FAIL full_write cyc=%0d got row=%0d col=%0d data=%0d required row=9 col=%0d data=650250",
                             cyc, bus.res_row, bus.res_col, bus.res_data, wcount);
                end
                wcount++;
            end
            if (bus.done_row) done_cyc = cyc;
            @(posedge clk);
        end
        #1;
        n_cmp++;
        if (wcount != 10 || done_cyc != 121) begin
            n_bad++;
            $display("FAIL full_count got writes=%0d done_cyc=%0d required writes=10 done_cyc=121", wcount, done_cyc);
        end
    endtask

    task automatic test_back_to_back();
        int wcount = 0;
        int first = 0, second = 0, ndone = 0;
        int row, col;
        load_identity();
        bus.res_add = 4'd0;
        bus.begin_mult = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 245; cyc++) begin
            #1;
            if (bus.res_wr_en) begin
                row = (cyc > 122) ? 1 : 0;
                col = ((cyc > 122) ? cyc - 122 : cyc) / 12 - 1;
                n_cmp++;
                if (bus.res_row !== 4'(row) || bus.res_col !== 4'(col) || bus.res_data !== 20'(10*row + col)) begin
                    n_bad++;
                    $display("FAIL b2b_write cyc=%0d got row=%0d col=%0d data=%0d required row=%0d col=%0d data=%0d",
                             cyc, bus.res_row, bus.res_col, bus.res_data, row, col, 10*row + col);
                end
                wcount++;
            end
            if (bus.done_row) begin
                ndone++;
                if (first == 0) begin
                    first = cyc;
                    bus.res_add = 4'd1;
                end else begin
                    second = cyc;
                    bus.begin_mult = 1'b0;
                end
            end
            @(posedge clk);
        end
        #1;
        n_cmp++;
        if (first != 121 || second != 243 || ndone != 2) begin
            n_bad++;
            $display("FAIL b2b_done got first=%0d second=%0d count=%0d required 121 243 2", first, second, ndone);
        end
        n_cmp++;
        if (wcount != 20 || bus.op_rd_en !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_end got writes=%0d rd_en=%b required writes=20 rd_en=0", wcount, bus.op_rd_en);
        end
    endtask

    task automatic test_drop_begin();
        int wcount = 0, ndone = 0, done_cyc = 0;
        load_identity();
        bus.res_add = 4'd5;
        bus.begin_mult = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 130; cyc++) begin
            #1;
            if (cyc == 5) bus.begin_mult = 1'b0;
            if (bus.res_wr_en) begin
                n_cmp++;
                if (bus.res_data !== 20'(50 + wcount) || bus.res_col !== 4'(wcount)) begin
                    n_bad++;
                    $display("FAIL drop_write cyc=%0d got col=%0d data=%0d required col=%0d data=%0d",
                             cyc, bus.res_col, bus.res_data, wcount, 50 + wcount);
                end
                wcount++;
            end
            if (bus.done_row) begin
                ndone++;
                done_cyc = cyc;
            end
            @(posedge clk);
        end
        #1;
        n_cmp++;
        if (wcount != 10 || ndone != 1 || done_cyc != 121) begin
            n_bad++;
            $display("FAIL drop_count got writes=%0d dones=%0d done_cyc=%0d required 10 1 121", wcount, ndone, done_cyc);
        end
    endtask

    task automatic test_reset_mid_row();
        int wcount = 0, ndone = 0, done_cyc = 0;
        load_identity();
        bus.res_add = 4'd4;
        bus.begin_mult = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc < 50; cyc++) begin
            #1;
            if (cyc == 1) bus.begin_mult = 1'b0;
            @(posedge clk);
        end
        #1 n_reset = 1'b0;
        #1;
        n_cmp++;
        if ({bus.op_rd_en, bus.res_wr_en, bus.done_row, bus.op_row, bus.op_k, bus.op_col,
             bus.res_row, bus.res_col, bus.res_data} !== '0) begin
            n_bad++;
            $display("FAIL midreset_async got rd=%b row=%0d k=%0d data=%0d required all zero",
                     bus.op_rd_en, bus.op_row, bus.op_k, bus.res_data);
        end
        repeat (2) @(posedge clk);
        #1 n_reset = 1'b1;
        for (int cyc = 0; cyc < 130; cyc++) begin
            @(posedge clk);
            #1;
            if (bus.res_wr_en) wcount++;
            if (bus.done_row || bus.op_rd_en) ndone++;
        end
        n_cmp++;
        if (wcount != 0 || ndone != 0 || dut.state_q !== IDLE) begin
            n_bad++;
            $display("FAIL midreset_quiet got writes=%0d activity=%0d state=%0d required 0 0 IDLE",
                     wcount, ndone, dut.state_q);
        end
        bus.res_add = 4'd7;
        bus.begin_mult = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 125; cyc++) begin
            #1;
            if (cyc == 1) bus.begin_mult = 1'b0;
            if (bus.res_wr_en) begin
                n_cmp++;
                if (bus.res_row !== 4'd7 || bus.res_data !== 20'(70 + wcount) || bus.res_col !== 4'(wcount)) begin
                    n_bad++;
                    $display("FAIL fresh_write cyc=%0d got row=%0d col=%0d data=%0d required row=7 col=%0d data=%0d",
                             cyc, bus.res_row, bus.res_col, bus.res_data, wcount, 70 + wcount);
                end
                wcount++;
            end
            if (bus.done_row) done_cyc = cyc;
            @(posedge clk);
        end
        #1;
        n_cmp++;
        if (wcount != 10 || done_cyc != 121) begin
            n_bad++;
            $display("FAIL fresh_count got writes=%0d done_cyc=%0d required 10 121", wcount, done_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_full_scale();
        test_back_to_back();
        test_drop_begin();
        test_reset_mid_row();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
